// File: rtl/srff_pkg.sv
// srff_pkg: shared definitions for the SR flip-flop bank.
//   - sr_mode_e : encoding of the policy applied when S and R are both high
//   - parameter limits checked by srff_bank at elaboration
//   - sr_next() : one-bit next-state function of (s, r, q, mode)
package srff_pkg;

  typedef enum logic [1:0] {
    SR_HOLD    = 2'd0,
    SR_SET_DOM = 2'd1,
    SR_RST_DOM = 2'd2,
    SR_TOGGLE  = 2'd3
  } sr_mode_e;

  localparam int MODE_MAX  = 3;
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
  localparam int CNT_W_MIN = 2;
  localparam int CNT_W_MAX = 16;

  function automatic logic sr_next(input logic i_s, input logic i_r,
                                   input logic i_q, input sr_mode_e i_mode);
    logic v_next;
    v_next = i_q;
    case ({i_s, i_r})
      2'b10: v_next = 1'b1;
      2'b01: v_next = 1'b0;
      2'b11: begin
        case (i_mode)
          SR_HOLD:    v_next = i_q;
          SR_SET_DOM: v_next = 1'b1;
          SR_RST_DOM: v_next = 1'b0;
          SR_TOGGLE:  v_next = ~i_q;
          default:    v_next = i_q;
        endcase
      end
      default: v_next = i_q;
    endcase
    return v_next;
  endfunction

endpackage

// File: rtl/srff_cell.sv
// srff_cell: a single SR channel.
//   i_clk, i_res (async, active-low), i_en, i_clr (sync), i_s, i_r
//   o_q        : channel state
//   o_chg      : one-cycle pulse after an enabled update changed o_q
//   o_conflict : sticky, set when S=R=1 is sampled on an enabled edge
module srff_cell
  import srff_pkg::*;
#(
  parameter int   MODE = 0,
  parameter logic INIT = 1'b0
) (
  input  logic i_clk,
  input  logic i_res,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_s,
  input  logic i_r,
  output logic o_q,
  output logic o_chg,
  output logic o_conflict
);

  localparam sr_mode_e L_MODE = sr_mode_e'(MODE[1:0]);

  logic r_q;
  logic r_chg;
  logic r_conflict;
  logic w_q_next;

  assign w_q_next = sr_next(i_s, i_r, r_q, L_MODE);

  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      r_q        <= INIT;
      r_chg      <= 1'b0;
      r_conflict <= 1'b0;
    end else if (i_clr) begin
      // A clear may change q, but it is not reported as a change.
      r_q        <= INIT;
      r_chg      <= 1'b0;
      r_conflict <= 1'b0;
    end else if (i_en) begin
      r_q   <= w_q_next;
      r_chg <= w_q_next ^ r_q;
      if (i_s && i_r) begin
        r_conflict <= 1'b1;
      end
    end else begin
      r_chg <= 1'b0;
    end
  end

  assign o_q        = r_q;
  assign o_chg      = r_chg;
  assign o_conflict = r_conflict;

endmodule

// File: rtl/srff_bank.sv
// srff_bank: WIDTH independent SR flip-flops with shared enable and clear.
//   clk, res (async, active-low), en, clr (sync, overrides en)
//   s, r         : per-channel set / reset requests
//   q, qn        : channel state and its complement
//   chg          : per-channel one-cycle change pulse
//   conflict     : per-channel sticky S=R=1 flag
//   conflict_cnt : saturating count of enabled cycles with any S=R=1
//   irq          : OR of conflict, registered alongside it
module srff_bank
  import srff_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               MODE  = 0,
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] chg,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic             irq
);

  generate
    if (MODE < 0 || MODE > MODE_MAX || CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX ||
        WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_param
      $error("srff_bank: illegal parameter set WIDTH=%0d MODE=%0d CNT_W=%0d",
             WIDTH, MODE, CNT_W);
    end
  endgenerate

  localparam logic [CNT_W-1:0] L_CNT_MAX = '1;

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_chg;
  logic [WIDTH-1:0] w_conflict;
  logic             w_any_conflict;
  logic [CNT_W-1:0] r_cnt;
  logic             r_irq;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      srff_cell #(
        .MODE (MODE),
        .INIT (INIT[gi])
      ) u_cell (
        .i_clk      (clk),
        .i_res      (res),
        .i_en       (en),
        .i_clr      (clr),
        .i_s        (s[gi]),
        .i_r        (r[gi]),
        .o_q        (w_q[gi]),
        .o_chg      (w_chg[gi]),
        .o_conflict (w_conflict[gi])
      );
    end
  endgenerate

  assign w_any_conflict = |(s & r);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_cnt <= '0;
      r_irq <= 1'b0;
    end else if (clr) begin
      r_cnt <= '0;
      r_irq <= 1'b0;
    end else if (en) begin
      // One increment per cycle no matter how many channels conflict.
      if (w_any_conflict && (r_cnt != L_CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Mirrors the conflict flags as they will be after this edge.
      r_irq <= |(w_conflict | (s & r));
    end
  end

  assign q            = w_q;
  assign qn           = ~w_q;
  assign chg          = w_chg;
  assign conflict     = w_conflict;
  assign conflict_cnt = r_cnt;
  assign irq          = r_irq;

endmodule

// File: tb/tb_srff_bank.sv
// tb_srff_bank: four 8-bit banks (MODE 0..3, CNT_W=8) plus one MODE 0 bank
// with CNT_W=2, all driven by the same stimulus. Expected values are pushed
// into a scoreboard tagged with the cycle they apply to; a monitor pops and
// compares them on the falling edge, or on demand for between-edge checks.
module tb_srff_bank;

  localparam int F_Q    = 0;
  localparam int F_QN   = 1;
  localparam int F_CHG  = 2;
  localparam int F_CONF = 3;
  localparam int F_CNT  = 4;
  localparam int F_IRQ  = 5;
  localparam int I_SAT  = 4;

  logic       clk = 1'b0;
  logic       res;
  logic       en;
  logic       clr;
  logic [7:0] s;
  logic [7:0] r;

  logic [7:0] q_w    [4];
  logic [7:0] qn_w   [4];
  logic [7:0] chg_w  [4];
  logic [7:0] conf_w [4];
  logic [7:0] cnt_w  [4];
  logic       irq_w  [4];

  logic [7:0] q_s, qn_s, chg_s, conf_s;
  logic [1:0] cnt_s;
  logic       irq_s;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      srff_bank #(.WIDTH(8), .MODE(gi), .INIT(8'hA5), .CNT_W(8)) u_dut (
        .clk          (clk),
        .res          (res),
        .en           (en),
        .clr          (clr),
        .s            (s),
        .r            (r),
        .q            (q_w[gi]),
        .qn           (qn_w[gi]),
        .chg          (chg_w[gi]),
        .conflict     (conf_w[gi]),
        .conflict_cnt (cnt_w[gi]),
        .irq          (irq_w[gi])
      );
    end
  endgenerate

  srff_bank #(.WIDTH(8), .MODE(0), .INIT(8'hA5), .CNT_W(2)) u_sat (
    .clk          (clk),
    .res          (res),
    .en           (en),
    .clr          (clr),
    .s            (s),
    .r            (r),
    .q            (q_s),
    .qn           (qn_s),
    .chg          (chg_s),
    .conflict     (conf_s),
    .conflict_cnt (cnt_s),
    .irq          (irq_s)
  );

  typedef struct {
    int         cyc;
    int         inst;
    int         fld;
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  event ev_sample;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] get(input int inst, input int fld);
    if (inst == I_SAT) begin
      case (fld)
        F_Q:     return q_s;
        F_QN:    return qn_s;
        F_CHG:   return chg_s;
        F_CONF:  return conf_s;
        F_CNT:   return {6'b0, cnt_s};
        default: return {7'b0, irq_s};
      endcase
    end
    case (fld)
      F_Q:     return q_w[inst];
      F_QN:    return qn_w[inst];
      F_CHG:   return chg_w[inst];
      F_CONF:  return conf_w[inst];
      F_CNT:   return cnt_w[inst];
      default: return {7'b0, irq_w[inst]};
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  chk_t       m_c;
  logic [7:0] m_act;
  always @(negedge clk or ev_sample) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_c = sb.pop_front();
      n_tests++;
      if (m_c.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s inst%0d: check for cycle %0d never sampled (now %0d)",
                 m_c.name, m_c.inst, m_c.cyc, cyc);
      end else begin
        m_act = get(m_c.inst, m_c.fld);
        if (m_act !== m_c.exp) begin
          n_fail++;
          $display("FAIL %s inst%0d cyc%0d: got %h expected %h",
                   m_c.name, m_c.inst, cyc, m_act, m_c.exp);
        end else begin
          $display("[TB] ok %s inst%0d cyc%0d = %h", m_c.name, m_c.inst, cyc, m_act);
        end
      end
    end
  end

  // Expectation for the state after the next rising edge.
  task automatic chk(input int inst, input int fld, input logic [7:0] v, input string nm);
    chk_t c;
    c.cyc = cyc + 1; c.inst = inst; c.fld = fld; c.exp = v; c.name = nm;
    sb.push_back(c);
  endtask

  // Expectation for the current state, checked on ev_sample.
  task automatic chk_now(input int inst, input int fld, input logic [7:0] v, input string nm);
    chk_t c;
    c.cyc = cyc; c.inst = inst; c.fld = fld; c.exp = v; c.name = nm;
    sb.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [7:0] hold_q [4];
  logic [7:0] m3_q   [3];

  initial begin
    hold_q = '{8'h00, 8'h01, 8'h00, 8'h01};
    m3_q   = '{8'h01, 8'h00, 8'h01};
    res = 1'b1; en = 1'b0; clr = 1'b0; s = 8'h00; r = 8'h00;

    // Reset asserted between edges takes effect immediately.
    step();
    res = 1'b0;
    #1;
    chk_now(0, F_Q,    8'hA5, "rst_q");
    chk_now(0, F_QN,   8'h5A, "rst_qn");
    chk_now(0, F_CHG,  8'h00, "rst_chg");
    chk_now(0, F_CONF, 8'h00, "rst_conf");
    chk_now(0, F_CNT,  8'h00, "rst_cnt");
    chk_now(0, F_IRQ,  8'h00, "rst_irq");
    chk_now(I_SAT, F_CNT, 8'h00, "rst_cnt_sat");
    -> ev_sample;
    step();

    // Release, then idle with enable high: nothing changes.
    res = 1'b1; en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk(0, F_Q,   8'hA5, "idle_q");
      chk(0, F_CHG, 8'h00, "idle_chg");
      step();
    end

    // Per-channel set/reset.
    s = 8'h0F; r = 8'hF0;
    for (int i = 0; i < 5; i++) begin
      chk(i, F_Q,   8'h0F, "sr_q");
      chk(i, F_CHG, 8'hAA, "sr_chg");
    end
    step();
    s = 8'h00; r = 8'h00;
    for (int i = 0; i < 4; i++) chk(i, F_CHG, 8'h00, "sr_chg_drop");
    chk(0, F_Q, 8'h0F, "sr_q_hold");
    step();

    // Clear all channels to zero before the mode sweep.
    r = 8'hFF;
    chk(0, F_Q, 8'h00, "zero_q");
    step();

    // MODE sweep: s=r=1 on channel 0 for three cycles.
    s = 8'h01; r = 8'h01;
    for (int k = 0; k < 3; k++) begin
      chk(0, F_Q,   8'h00,   "m0_q");
      chk(1, F_Q,   8'h01,   "m1_q");
      chk(2, F_Q,   8'h00,   "m2_q");
      chk(3, F_Q,   m3_q[k], "m3_q");
      chk(3, F_CHG, 8'h01,   "m3_chg");
      chk(1, F_CHG, (k == 0) ? 8'h01 : 8'h00, "m1_chg");
      chk(0, F_CNT, 8'(k + 1), "sweep_cnt");
      step();
    end
    for (int i = 0; i < 4; i++) begin
      chk_now(i, F_CONF, 8'h01, "sweep_conf");
      chk_now(i, F_IRQ,  8'h01, "sweep_irq");
      chk_now(i, F_CNT,  8'h03, "sweep_cnt3");
    end
    -> ev_sample;

    // Enable low: everything holds.
    en = 1'b0; s = 8'hFF; r = 8'h00;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) chk(i, F_Q, hold_q[i], "en0_q");
      chk(3, F_CHG,  8'h00, "en0_chg");
      chk(0, F_CONF, 8'h01, "en0_conf");
      chk(0, F_CNT,  8'h03, "en0_cnt");
      step();
    end

    // Clear with enable low.
    clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk(i, F_Q,    8'hA5, "clr_q");
      chk(i, F_CHG,  8'h00, "clr_chg");
      chk(i, F_CONF, 8'h00, "clr_conf");
      chk(i, F_CNT,  8'h00, "clr_cnt");
      chk(i, F_IRQ,  8'h00, "clr_irq");
    end
    chk(I_SAT, F_CNT, 8'h00, "clr_cnt_sat");
    step();

    // Saturation on the 2-bit counter: conflicts on channels 1 and 3.
    clr = 1'b0; en = 1'b1; s = 8'h0A; r = 8'h0A;
    for (int k = 0; k < 5; k++) begin
      chk(I_SAT, F_CNT, (k < 3) ? 8'(k + 1) : 8'h03, "sat_cnt");
      chk(0, F_CNT, 8'(k + 1), "wide_cnt");
      step();
    end
    chk_now(I_SAT, F_CONF, 8'h0A, "sat_conf");
    chk_now(I_SAT, F_IRQ,  8'h01, "sat_irq");
    -> ev_sample;

    // Clear and conflict in the same cycle: clear wins.
    clr = 1'b1;
    chk(0, F_CNT,  8'h00, "clrwin_cnt");
    chk(0, F_CONF, 8'h00, "clrwin_conf");
    chk(I_SAT, F_CNT, 8'h00, "clrwin_cnt_sat");
    chk(0, F_IRQ,  8'h00, "clrwin_irq");
    step();

    // Async reset in the middle of a MODE 3 toggle.
    clr = 1'b0; s = 8'h01; r = 8'h01;
    chk(3, F_Q,   8'hA4, "tog_q");
    chk(3, F_CHG, 8'h01, "tog_chg");
    chk(3, F_CNT, 8'h01, "tog_cnt");
    step();
    @(negedge clk);
    #1;
    res = 1'b0;
    #1;
    chk_now(3, F_Q,    8'hA5, "arst_q");
    chk_now(3, F_QN,   8'h5A, "arst_qn");
    chk_now(3, F_CHG,  8'h00, "arst_chg");
    chk_now(3, F_CNT,  8'h00, "arst_cnt");
    chk_now(3, F_CONF, 8'h00, "arst_conf");
    -> ev_sample;
    step();
    res = 1'b1; s = 8'h00; r = 8'h00;
    chk(3, F_Q,   8'hA5, "rel_q");
    chk(3, F_CHG, 8'h00, "rel_chg");
    step();
    chk(3, F_CHG, 8'h00, "rel_chg2");
    step();

    repeat (3) step();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks left unsampled, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/srff_bank.md
# srff_bank

Parametrised bank of WIDTH independent set/reset flip-flops with a shared enable, synchronous clear and a build-time policy for the S=R=1 case. It also provides per-channel change pulses, sticky conflict flags and a saturating conflict counter. It sits between raw control/status strobes and the register/interrupt logic, and replaces single-bit SR flops in the sequential library.

## Interface
Parameters:
- WIDTH, 8, number of independent SR channels (1..64)
- MODE, 0, policy when s[i]=r[i]=1: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle (JK behaviour)
- INIT, all zeros, WIDTH-bit value loaded into q by reset and by clr
- CNT_W, 8, width of conflict_cnt (2..16)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- res  in  1  reset, asynchronous, active-low
- en  in  1  update enable for q, chg, conflict and conflict_cnt
- clr  in  1  synchronous clear; acts regardless of en
- s  in  WIDTH  per-channel set request
- r  in  WIDTH  per-channel reset request
- q  out  WIDTH  channel state
- qn  out  WIDTH  ~q, combinational from the q register
- chg  out  WIDTH  one-cycle pulse; bit i is high in the cycle where q[i] has just changed value
- conflict  out  WIDTH  sticky flag; s[i]=r[i]=1 was sampled while en=1
- conflict_cnt  out  CNT_W  saturating count of enabled cycles in which any channel had s&r
- irq  out  1  |conflict, registered together with conflict

## Operation
- Per-channel next state when en=1 and clr=0:
  - s=0, r=0: hold
  - s=1, r=0: 1
  - s=0, r=1: 0
  - s=1, r=1: per MODE (hold, 1, 0, or ~q)
- en=0 and clr=0:
  - q holds
  - chg=0
  - conflict and conflict_cnt hold
- clr=1, overriding en, s and r:
  - q<=INIT
  - conflict<=0
  - conflict_cnt<=0
  - irq<=0
  - chg<=0, even if q changes as a result of the clear
- chg[i] is registered on the same edge as q[i], as q_next[i]^q[i]. It is high only in the cycle following an enabled non-clear update that changed q[i].
- conflict[i] sets on any enabled, non-clear edge with s[i]&r[i]. It is cleared only by clr or reset. MODE does not affect conflict logging.
- conflict_cnt increments by exactly 1 per qualifying cycle, regardless of how many channels conflict. It saturates at 2^CNT_W-1 and never wraps.
- Channels are fully independent; no cross-channel priority exists.

## Timing
- Reset (res=0), asynchronous:
  - q=INIT, qn=~INIT
  - chg=0, conflict=0, conflict_cnt=0, irq=0
  - These values hold while res=0.
- Reset deassertion is synchronised externally. The first update occurs on the first rising edge with res=1.
- Latency: s/r/en/clr are sampled at edge N; q, chg, conflict, irq and conflict_cnt reflect them after edge N.
- qn has zero cycles of latency from q.
- Reset asserted mid-operation: all state returns to reset values immediately, with no wait for clk. An in-flight chg pulse is dropped.
- MODE=3 with s=r=1 held for k enabled cycles: q toggles every cycle, and chg[i] stays high for all k cycles.
- Saturation: at the maximum count, a further qualifying cycle leaves conflict_cnt at the maximum.
- clr and conflict in the same cycle: the clear wins, and conflict_cnt=0 after the edge.

## Structure
- Package srff_pkg holds:
  - the MODE encodings as named constants (SR_HOLD=0, SR_SET_DOM=1, SR_RST_DOM=2, SR_TOGGLE=3)
  - a function computing the 1-bit next state from (s, r, q, mode)
- Sub-module srff_cell: one channel containing the q flop, the chg flop and the conflict flop, with inputs en and clr.
- srff_bank instantiates WIDTH cells in a generate loop and owns conflict_cnt and irq.
- Illegal MODE or CNT_W values are rejected by an elaboration-time check.

## Test plan
- Reset, then hold: WIDTH=8, INIT=8'hA5, res=0 mid-cycle -> q=8'hA5 and qn=8'h5A immediately. After release with s=r=0, en=1 for 5 cycles -> q unchanged and chg=0.
- Set/reset per channel: s=8'h0F, r=8'hF0 from q=8'hA5 for one enabled cycle -> q=8'h0F and chg=8'hAA for exactly one cycle. The next idle cycle -> chg=0.
- MODE sweep on channel 0, with s=r=1 for 3 enabled cycles from q=0:
  - MODE 0 -> q stays 0
  - MODE 1 -> q=1
  - MODE 2 -> q=0
  - MODE 3 -> q toggles 1,0,1 and chg[0] is high all 3 cycles
  - Every MODE -> conflict[0]=1, irq=1, conflict_cnt=3
- Enable and clear: en=0 with s=8'hFF for 4 cycles -> q, conflict and cnt unchanged. Then clr=1 with en=0 -> q=INIT, conflict=0, cnt=0, chg=0.
- Saturation: CNT_W=2, 5 enabled conflict cycles on channels 1 and 3 simultaneously -> cnt goes 1,2,3,3,3 (one increment per cycle) and conflict=8'h0A.
- Async reset mid-toggle: MODE 3 toggling, res pulled low between edges -> q=INIT and cnt=0 before the next edge, with no chg pulse after release.
